// File: rtl/pll_lock_reset_seq.sv
// PLL lock supervisor: synchronises rPLL LOCK, retries PLL reset on timeout, qualifies lock
// stability, then releases the serialiser and pixel-domain resets in order.
module pll_lock_reset_seq #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT   = 270000,
  parameter int unsigned STABLE_CYCLES  = 2700,
  parameter int unsigned GAP_CYCLES     = 64,
  parameter int unsigned RETRY_W        = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pll_lock,
  output logic               pll_reset,
  output logic               serdes_rst_n,
  output logic               pixel_rst_n,
  output logic               ready,
  output logic               lock_lost,
  output logic [RETRY_W-1:0] retry_cnt
);

  localparam int unsigned MaxAB  = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned MaxCD  = (STABLE_CYCLES > GAP_CYCLES) ? STABLE_CYCLES : GAP_CYCLES;
  localparam int unsigned MaxCnt = (MaxAB > MaxCD) ? MaxAB : MaxCD;
  localparam int unsigned CntW   = (MaxCnt > 1) ? $clog2(MaxCnt) : 1;

  localparam logic [CntW-1:0] RstLast     = CntW'(PLL_RST_CYCLES - 1);
  localparam logic [CntW-1:0] TimeoutLast = CntW'(LOCK_TIMEOUT - 1);
  localparam logic [CntW-1:0] StableLast  = CntW'(STABLE_CYCLES - 1);
  localparam logic [CntW-1:0] GapLast     = CntW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    StRstPll,
    StWaitLock,
    StStable,
    StRelSerdes,
    StRun,
    StLost
  } state_e;

  state_e                 state_q;
  logic [CntW-1:0]        cnt_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pll_lock};
    end
  end

  assign lock_s = sync_q[SYNC_STAGES-1];

  // Outputs are set on the edge that enters the state that owns them, so they track the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StRstPll;
      cnt_q        <= '0;
      pll_reset    <= 1'b1;
      serdes_rst_n <= 1'b0;
      pixel_rst_n  <= 1'b0;
      ready        <= 1'b0;
      lock_lost    <= 1'b0;
      retry_cnt    <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
      case (state_q)
        StRstPll: begin
          if (cnt_q == RstLast) begin
            state_q   <= StWaitLock;
            cnt_q     <= '0;
            pll_reset <= 1'b0;
          end
        end
        StWaitLock: begin
          if (lock_s) begin
            state_q <= StStable;
            cnt_q   <= '0;
          end else if (cnt_q == TimeoutLast) begin
            state_q   <= StRstPll;
            cnt_q     <= '0;
            pll_reset <= 1'b1;
            if (retry_cnt != '1) begin
              retry_cnt <= retry_cnt + 1'b1;
            end
          end
        end
        StStable: begin
          if (!lock_s) begin
            state_q <= StWaitLock;
            cnt_q   <= '0;
          end else if (cnt_q == StableLast) begin
            state_q      <= StRelSerdes;
            cnt_q        <= '0;
            serdes_rst_n <= 1'b1;
          end
        end
        StRelSerdes: begin
          if (!lock_s) begin
            state_q      <= StLost;
            cnt_q        <= '0;
            serdes_rst_n <= 1'b0;
            pixel_rst_n  <= 1'b0;
            ready        <= 1'b0;
            lock_lost    <= 1'b1;
          end else if (cnt_q == GapLast) begin
            state_q     <= StRun;
            cnt_q       <= '0;
            pixel_rst_n <= 1'b1;
            ready       <= 1'b1;
          end
        end
        StRun: begin
          if (!lock_s) begin
            state_q      <= StLost;
            cnt_q        <= '0;
            serdes_rst_n <= 1'b0;
            pixel_rst_n  <= 1'b0;
            ready        <= 1'b0;
            lock_lost    <= 1'b1;
          end
        end
        StLost: begin
          state_q   <= StRstPll;
          cnt_q     <= '0;
          pll_reset <= 1'b1;
        end
        default: begin
          state_q      <= StRstPll;
          cnt_q        <= '0;
          pll_reset    <= 1'b1;
          serdes_rst_n <= 1'b0;
          pixel_rst_n  <= 1'b0;
          ready        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// Bench for pll_lock_reset_seq: directed bring-up/loss/retry scenarios plus random lock
// patterns, all outputs compared every cycle against a phase/elapsed-time model.
module tb_pll_lock_reset_seq;

  localparam int unsigned SYNC    = 2;
  localparam int unsigned RST_N   = 4;
  localparam int unsigned TIMEOUT = 50;
  localparam int unsigned STABLE  = 10;
  localparam int unsigned GAP     = 5;

  localparam int PH_RST = 0, PH_WAIT = 1, PH_STAB = 2, PH_REL = 3, PH_RUN = 4, PH_LOST = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pll_lock = 1'b0;

  logic       a_pll_reset, a_serdes, a_pixel, a_ready, a_lost;
  logic [7:0] a_retry;
  logic       b_pll_reset, b_serdes, b_pixel, b_ready, b_lost;
  logic [1:0] b_retry;

  int errors = 0;
  int checks = 0;

  // Model state: current phase, cycles spent in it, sticky loss flag, retries, lock pipeline.
  int              m_phase;
  int              m_t;
  int              m_retry;
  bit              m_lost;
  logic [SYNC-1:0] m_sync;

  always #5 clk = ~clk;

  pll_lock_reset_seq #(
    .SYNC_STAGES(SYNC), .PLL_RST_CYCLES(RST_N), .LOCK_TIMEOUT(TIMEOUT),
    .STABLE_CYCLES(STABLE), .GAP_CYCLES(GAP), .RETRY_W(8)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock), .pll_reset(a_pll_reset),
    .serdes_rst_n(a_serdes), .pixel_rst_n(a_pixel), .ready(a_ready),
    .lock_lost(a_lost), .retry_cnt(a_retry)
  );

  pll_lock_reset_seq #(
    .SYNC_STAGES(SYNC), .PLL_RST_CYCLES(RST_N), .LOCK_TIMEOUT(TIMEOUT),
    .STABLE_CYCLES(STABLE), .GAP_CYCLES(GAP), .RETRY_W(2)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock), .pll_reset(b_pll_reset),
    .serdes_rst_n(b_serdes), .pixel_rst_n(b_pixel), .ready(b_ready),
    .lock_lost(b_lost), .retry_cnt(b_retry)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic e_pll, e_ser, e_pix;
    int   e_bret;
    e_pll  = (m_phase == PH_RST);
    e_ser  = (m_phase == PH_REL) || (m_phase == PH_RUN);
    e_pix  = (m_phase == PH_RUN);
    e_bret = (m_retry > 3) ? 3 : m_retry;
    chk("a_pll_reset", 32'(a_pll_reset), 32'(e_pll));
    chk("a_serdes_rst_n", 32'(a_serdes), 32'(e_ser));
    chk("a_pixel_rst_n", 32'(a_pixel), 32'(e_pix));
    chk("a_ready", 32'(a_ready), 32'(e_pix));
    chk("a_lock_lost", 32'(a_lost), 32'(m_lost));
    chk("a_retry_cnt", 32'(a_retry), 32'(m_retry > 255 ? 255 : m_retry));
    chk("a_order", 32'(a_pixel & ~a_serdes), 32'(0));
    chk("b_pll_reset", 32'(b_pll_reset), 32'(e_pll));
    chk("b_ready", 32'(b_ready), 32'(e_pix));
    chk("b_retry_cnt", 32'(b_retry), 32'(e_bret));
  endtask

  task automatic model_reset();
    m_phase = PH_RST;
    m_t     = 0;
    m_retry = 0;
    m_lost  = 0;
    m_sync  = '0;
  endtask

  // Advances the model over one clock edge, using the lock level seen before that edge.
  task automatic model_edge();
    bit ls;
    int np;
    ls = m_sync[SYNC-1];
    np = m_phase;
    case (m_phase)
      PH_RST:  if (m_t + 1 >= RST_N) np = PH_WAIT;
      PH_WAIT: begin
        if (ls) np = PH_STAB;
        else if (m_t + 1 >= TIMEOUT) begin
          np = PH_RST;
          m_retry++;
        end
      end
      PH_STAB: begin
        if (!ls) np = PH_WAIT;
        else if (m_t + 1 >= STABLE) np = PH_REL;
      end
      PH_REL: begin
        if (!ls) begin
          np = PH_LOST;
          m_lost = 1;
        end else if (m_t + 1 >= GAP) np = PH_RUN;
      end
      PH_RUN: begin
        if (!ls) begin
          np = PH_LOST;
          m_lost = 1;
        end
      end
      default: np = PH_RST;
    endcase
    m_t     = (np == m_phase) ? m_t + 1 : 0;
    m_phase = np;
    m_sync  = {m_sync[SYNC-2:0], pll_lock};
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  // Asserts rst_n between edges, checks the immediate effect, then releases after one edge.
  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;
  endtask

  initial begin
    int lat_s, lat_p, lat_r, n;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Clean bring-up: lock 20 cycles after release.
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 3) chk("pll_reset_hold", 32'(a_pll_reset), 32'(1));
      if (i == 4) chk("pll_reset_release", 32'(a_pll_reset), 32'(0));
    end
    pll_lock = 1'b1;
    lat_s = -1;
    lat_p = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (lat_s < 0 && a_serdes === 1'b1) lat_s = i;
      if (lat_p < 0 && a_pixel === 1'b1) lat_p = i;
    end
    chk("serdes_latency", 32'(lat_s), 32'(13));
    chk("pixel_latency", 32'(lat_p), 32'(18));

    // Loss in RUN, then relock; lock_lost must stay set.
    pll_lock = 1'b0;
    lat_r = -1;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (lat_r < 0 && a_ready === 1'b0) lat_r = i;
    end
    chk("loss_latency", 32'(lat_r), 32'(SYNC + 1));
    chk("lock_lost_set", 32'(a_lost), 32'(1));
    pll_lock = 1'b1;
    repeat (40) step();
    chk("relock_ready", 32'(a_ready), 32'(1));
    chk("lock_lost_sticky", 32'(a_lost), 32'(1));

    // Stability glitch: 3-cycle drop at cycle 6 of qualification.
    pll_lock = 1'b0;
    do_reset();
    repeat (10) step();
    pll_lock = 1'b1;
    n = 0;
    while (!(m_phase == PH_STAB && m_t == 6) && n < 40) begin
      step();
      n++;
    end
    chk("reach_stable", 32'(n < 40), 32'(1));
    pll_lock = 1'b0;
    repeat (3) step();
    pll_lock = 1'b1;
    lat_s = -1;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (lat_s < 0 && a_serdes === 1'b1) lat_s = i;
    end
    chk("glitch_requalify", 32'(lat_s), 32'(13));
    chk("glitch_retry", 32'(a_retry), 32'(0));

    // No lock: retries every 54 cycles; the 2-bit counter saturates.
    pll_lock = 1'b0;
    do_reset();
    for (int i = 1; i <= 330; i++) begin
      step();
      if (i == 269) chk("retry_before_5th", 32'(a_retry), 32'(4));
      if (i == 270) chk("retry_5th", 32'(a_retry), 32'(5));
    end
    chk("retry_6", 32'(a_retry), 32'(6));
    chk("retry_saturated", 32'(b_retry), 32'(3));

    // Random lock patterns.
    do_reset();
    for (int k = 0; k < 40; k++) begin
      pll_lock = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 80)) step();
    end

    // Async reset in the middle of REL_SERDES.
    pll_lock = 1'b0;
    do_reset();
    pll_lock = 1'b1;
    n = 0;
    while (m_phase != PH_REL && n < 100) begin
      step();
      n++;
    end
    chk("reach_rel_serdes", 32'(n < 100), 32'(1));
    step();
    #2;
    do_reset();
    chk("async_lock_lost", 32'(a_lost), 32'(0));
    chk("async_retry", 32'(a_retry), 32'(0));
    repeat (5) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
